// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and default widths for the instruction fetch queue.
package fetch_pkg;

    localparam int FETCH_N = 24;
    localparam int FETCH_A = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_A-1:0] pc;
        logic [FETCH_N-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Memory, redirect and decode-side handshake signals of the fetch controller.
interface instruction_fetch_queue_if #(
    parameter int N = fetch_pkg::FETCH_N,
    parameter int A = fetch_pkg::FETCH_A
);
    logic         start;
    logic [A-1:0] address;
    logic [N-1:0] instruction;
    logic         redirect_valid;
    logic [A-1:0] redirect_target;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_instruction;
    logic [A-1:0] out_pc;
    logic         busy;

    modport slave (
        input  start, instruction, redirect_valid, redirect_target, out_ready,
        output address, out_valid, out_instruction, out_pc, busy
    );

    modport master (
        output start, instruction, redirect_valid, redirect_target, out_ready,
        input  address, out_valid, out_instruction, out_pc, busy
    );
endinterface

// File: rtl/instruction_fetch_queue_fetch_queue.sv
// Show-ahead FIFO holding prefetched {pc, instruction} words.
// When empty, the output holds the most recently popped word.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_A + FETCH_N,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_last;
    logic             w_pop;
    logic             w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_pop   = i_pop & ~o_empty;
    // A full queue still accepts a write when the head leaves in the same cycle.
    assign w_push  = i_push & ~i_flush & (~o_full | w_pop);
    assign o_data  = o_empty ? r_last : r_mem[r_rd_ptr];

    // Pointers, occupancy and last-popped word; flush drops contents but a same-cycle pop completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_pop) begin
                r_last <= r_mem[r_rd_ptr];
            end
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    // Entry storage; never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end
endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch controller: sequences instruction memory into a prefetch queue
// and restarts at the target on a redirect.
//   state | meaning
//   IDLE  | waiting for start, address forced to 0
//   FETCH | reading fetch_pc and pushing into the queue
//   WAIT  | queue full, holding fetch_pc until decode pops
//   DONE  | LAST_ADDR fetched, queue drains, no further pushes
module instruction_fetch_queue
    import fetch_pkg::*;
#(
    parameter int           N         = FETCH_N,
    parameter int           A         = FETCH_A,
    parameter int           DEPTH     = 4,
    parameter logic [A-1:0] LAST_ADDR = A'(14'h3FFF)
) (
    input logic                      clk,
    input logic                      rst,
    instruction_fetch_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_FETCH = FETCH;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0]     r_state;
    logic [A-1:0]   r_fetch_pc;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic           w_pop;
    logic           w_push;
    logic           w_redirect;
    logic [A+N-1:0] w_head;

    assign w_pop      = bus.out_ready & ~w_empty;
    assign w_redirect = bus.redirect_valid & (r_state != ST_IDLE);
    assign w_push     = (r_state == ST_FETCH) & (~w_full | w_pop) & ~w_redirect;

    assign bus.address         = (r_state == ST_IDLE) ? '0 : r_fetch_pc;
    assign bus.busy            = (r_state == ST_FETCH) | (r_state == ST_WAIT);
    assign bus.out_valid       = ~w_empty;
    assign bus.out_pc          = w_head[A+N-1:N];
    assign bus.out_instruction = w_head[N-1:0];

    fetch_queue #(
        .WIDTH (A + N),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (bus.out_ready),
        .i_flush (w_redirect),
        .i_data  ({r_fetch_pc, bus.instruction}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Occupancy can never exceed the queue depth.
    a_count_bound: assert property (@(posedge clk) disable iff (rst) w_count <= CW'(DEPTH));

    // State and fetch pointer; redirect outranks every other transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= '0;
        end else if (w_redirect) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= bus.redirect_target;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state    <= ST_FETCH;
                        r_fetch_pc <= '0;
                    end
                end
                ST_FETCH: begin
                    if (w_push) begin
                        // Stop on the final address without stepping past it.
                        if (r_fetch_pc == LAST_ADDR) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_fetch_pc <= r_fetch_pc + A'(1);
                        end
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_pop) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue with a queue-based reference model.
module tb_instruction_fetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [13:0] LAST  = 14'h5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    instruction_fetch_queue_if #(.N(24), .A(14)) bus ();

    assign bus.instruction = {10'h2A5, bus.address};

    instruction_fetch_queue #(
        .N         (24),
        .A         (14),
        .DEPTH     (DEPTH),
        .LAST_ADDR (LAST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: fetch state, next fetch address, queue of pcs, last popped word.
    typedef enum int {M_IDLE, M_FETCH, M_WAIT, M_DONE} mstate_t;
    mstate_t     m_st = M_IDLE;
    int          m_pc = 0;
    int          m_q[$];
    int          m_last_pc = 0;
    logic [23:0] m_last_instr = '0;

    task automatic model_step(input bit r, input bit s, input bit rv, input int tgt, input bit rdy);
        bit pop;
        if (r) begin
            m_st = M_IDLE; m_pc = 0; m_q.delete(); m_last_pc = 0; m_last_instr = '0;
        end else begin
            pop = (m_q.size() > 0) && rdy;
            if (pop) begin
                m_last_pc    = m_q.pop_front();
                m_last_instr = {10'h2A5, 14'(m_last_pc)};
            end
            if (rv && m_st != M_IDLE) begin
                m_q.delete(); m_pc = tgt; m_st = M_FETCH;
            end else begin
                case (m_st)
                    M_IDLE:  if (s) begin m_st = M_FETCH; m_pc = 0; end
                    M_FETCH: begin
                        if (m_q.size() < DEPTH) begin
                            m_q.push_back(m_pc);
                            if (m_pc == int'(LAST)) m_st = M_DONE;
                            else m_pc = (m_pc + 1) % 16384;
                        end else begin
                            m_st = M_WAIT;
                        end
                    end
                    M_WAIT:  if (pop) m_st = M_FETCH;
                    default: ;
                endcase
            end
        end
    endtask

    // One clock: inputs driven after the falling edge, outputs observed at the next falling edge.
    task automatic tick(input bit r, input bit s, input bit rv, input logic [13:0] tgt, input bit rdy);
        rst                 = r;
        bus.start           = s;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.out_ready       = rdy;
        model_step(r, s, rv, int'(tgt), rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 14'h0, 0);
        tick(1, 0, 0, 14'h0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_pc !== 14'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.out_pc); end
        n_cmp++; if (bus.out_instruction !== 24'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.out_instruction); end
        n_cmp++; if (bus.address !== 14'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.address); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    endtask

    task automatic test_stream();
        do_reset();
        tick(0, 1, 0, 14'h0, 1);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid: got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.address !== 14'h0) begin n_fail++; $display("FAIL stream_first_addr: got %h want 0", bus.address); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL stream_busy: got %0b want 1", bus.busy); end
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 14'h0, 1);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 14'(i) || bus.out_instruction !== (24'hA94000 + 24'(i))) begin
                n_fail++;
                $display("FAIL stream_word%0d: got v=%0b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         i, bus.out_valid, bus.out_pc, bus.out_instruction, 14'(i), 24'hA94000 + 24'(i));
            end
        end
    endtask

    task automatic test_wait();
        do_reset();
        tick(0, 1, 0, 14'h0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 14'h0, 0);
        n_cmp++; if (bus.address !== 14'h4 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL wait_hold: got addr=%h busy=%0b want addr=4 busy=1", bus.address, bus.busy); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 14'h0) begin n_fail++; $display("FAIL wait_head: got v=%0b pc=%h want v=1 pc=0", bus.out_valid, bus.out_pc); end
        tick(0, 0, 0, 14'h0, 1);
        n_cmp++; if (bus.out_pc !== 14'h1 || bus.address !== 14'h4) begin n_fail++; $display("FAIL wait_pop: got pc=%h addr=%h want pc=1 addr=4", bus.out_pc, bus.address); end
        tick(0, 0, 0, 14'h0, 0);
        n_cmp++; if (bus.address !== 14'h5 || bus.out_pc !== 14'h1) begin n_fail++; $display("FAIL wait_refill: got addr=%h pc=%h want addr=5 pc=1", bus.address, bus.out_pc); end
        tick(0, 0, 0, 14'h0, 1);
        n_cmp++; if (bus.out_pc !== 14'h2 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL wait_done: got pc=%h busy=%0b want pc=2 busy=0", bus.out_pc, bus.busy); end
    endtask

    task automatic test_redirect();
        do_reset();
        tick(0, 1, 0, 14'h0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 14'h0, 0);
        tick(0, 0, 1, 14'h100, 0);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.address !== 14'h100) begin n_fail++; $display("FAIL redir_flush: got v=%0b addr=%h want v=0 addr=100", bus.out_valid, bus.address); end
        n_cmp++; if (bus.out_pc !== 14'h0) begin n_fail++; $display("FAIL redir_hold_pc: got %h want 0", bus.out_pc); end
        tick(0, 0, 0, 14'h0, 1);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 14'h100) begin n_fail++; $display("FAIL redir_first: got v=%0b pc=%h want v=1 pc=100", bus.out_valid, bus.out_pc); end
        tick(0, 0, 0, 14'h0, 1);
        n_cmp++; if (bus.out_pc !== 14'h101 || bus.out_instruction !== 24'hA94101) begin n_fail++; $display("FAIL redir_second: got pc=%h ins=%h want pc=101 ins=a94101", bus.out_pc, bus.out_instruction); end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        tick(0, 1, 0, 14'h0, 0);
        tick(0, 0, 0, 14'h0, 0);
        tick(0, 0, 0, 14'h0, 1);
        tick(0, 0, 0, 14'h0, 1);
        n_cmp++; if (bus.out_pc !== 14'h2) begin n_fail++; $display("FAIL rpop_head: got %h want 2", bus.out_pc); end
        tick(0, 0, 1, 14'h100, 1);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 14'h2 || bus.out_instruction !== 24'hA94002) begin n_fail++; $display("FAIL rpop_kept: got v=%0b pc=%h ins=%h want v=0 pc=2 ins=a94002", bus.out_valid, bus.out_pc, bus.out_instruction); end
        tick(0, 0, 0, 14'h0, 1);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 14'h100) begin n_fail++; $display("FAIL rpop_target: got v=%0b pc=%h want v=1 pc=100", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_last_addr();
        int  seen[$];
        bit  rdy;
        do_reset();
        tick(0, 1, 0, 14'h0, 1);
        for (int i = 0; i < 40; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if (bus.out_valid === 1'b1 && rdy) seen.push_back(int'(bus.out_pc));
            tick(0, 0, 0, 14'h0, rdy);
        end
        n_cmp++; if (seen.size() != 6) begin n_fail++; $display("FAIL last_count: got %0d words want 6", seen.size()); end
        for (int i = 0; i < seen.size() && i < 8; i++) begin
            n_cmp++; if (seen[i] != i) begin n_fail++; $display("FAIL last_seq%0d: got %h want %h", i, seen[i], i); end
        end
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL last_drained: got v=%0b busy=%0b want 0 0", bus.out_valid, bus.busy); end
        n_cmp++; if (bus.out_pc !== LAST) begin n_fail++; $display("FAIL last_hold: got %h want %h", bus.out_pc, LAST); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        tick(0, 1, 0, 14'h0, 0);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 14'h0, 0);
        tick(1, 0, 0, 14'h0, 0);
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.address !== 14'h0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got v=%0b addr=%h busy=%0b want 0 0 0", bus.out_valid, bus.address, bus.busy); end
        n_cmp++; if (bus.out_pc !== 14'h0 || bus.out_instruction !== 24'h0) begin n_fail++; $display("FAIL rst_mid_head: got pc=%h ins=%h want 0 0", bus.out_pc, bus.out_instruction); end
        tick(0, 1, 0, 14'h0, 0);
        tick(0, 0, 0, 14'h0, 0);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 14'h0 || bus.out_instruction !== 24'hA94000) begin n_fail++; $display("FAIL rst_restart: got v=%0b pc=%h ins=%h want 1 0 a94000", bus.out_valid, bus.out_pc, bus.out_instruction); end
    endtask

    task automatic test_random();
        logic        exp_valid;
        logic [13:0] exp_pc;
        logic [23:0] exp_ins;
        logic [13:0] exp_addr;
        logic        exp_busy;
        logic [13:0] tgt;
        int          sel;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 2);
            tgt = (sel == 0) ? 14'($urandom_range(0, 7)) :
                  (sel == 1) ? 14'(14'h3FFC + 14'($urandom_range(0, 3))) : 14'($urandom);
            tick(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0), tgt, ($urandom_range(0, 2) != 0));
            exp_valid = (m_q.size() > 0);
            exp_pc    = exp_valid ? 14'(m_q[0]) : 14'(m_last_pc);
            exp_ins   = exp_valid ? {10'h2A5, exp_pc} : m_last_instr;
            exp_addr  = (m_st == M_IDLE) ? 14'h0 : 14'(m_pc);
            exp_busy  = (m_st == M_FETCH) || (m_st == M_WAIT);
            n_cmp++;
            if (bus.out_valid !== exp_valid || bus.out_pc !== exp_pc || bus.out_instruction !== exp_ins ||
                bus.address !== exp_addr || bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got v=%0b pc=%h ins=%h addr=%h busy=%0b want v=%0b pc=%h ins=%h addr=%h busy=%0b",
                         i, bus.out_valid, bus.out_pc, bus.out_instruction, bus.address, bus.busy,
                         exp_valid, exp_pc, exp_ins, exp_addr, exp_busy);
            end
        end
    endtask

    initial begin
        bus.start           = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.out_ready       = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_wait();
        test_redirect();
        test_redirect_pop();
        test_last_addr();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
